coso_calib_ctrl: RTL and testbench

- Auto-calibration and sequencing controller for the COSO TRNG unit.
- Drives the two 8-bit ring-oscillator configuration words and the oscillator enable.
- Sweeps the B-oscillator configuration while watching the beat counter's samples (8-bit count, valid strobe) until the averaged count falls inside a programmable window.
- Once locked, gates random output bits through and re-calibrates if the count drifts out of the window.

---
 rtl/coso_pkg.sv | 27 ++
 rtl/coso_sample_acc.sv | 39 +++
 rtl/coso_calib_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_coso_calib_ctrl.sv | 372 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/coso_pkg.sv
// Shared types and constants for the COSO TRNG calibration controller.
// Holds the FSM state encoding and the window-compare helper.
package coso_pkg;

  localparam int CFG_W = 8;
  localparam int CNT_W = 8;
  localparam int LEN_W = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RECONF,
    S_SETTLE,
    S_MEASURE,
    S_EVAL,
    S_LOCKED,
    S_FAIL
  } state_t;

  function automatic logic in_win(
    input logic [CNT_W-1:0] v,
    input logic [CNT_W-1:0] lo,
    input logic [CNT_W-1:0] hi
  );
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/coso_sample_acc.sv
// Strobe counter plus accumulator used for both settle and measure phases.
// o_done fires on the strobe that completes i_len samples.
module coso_sample_acc
  import coso_pkg::*;
#(
  parameter int LOG2_AVG = 3
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clr,
  input  logic             i_inc,
  input  logic [LEN_W-1:0] i_len,
  input  logic [CNT_W-1:0] i_sample,
  output logic             o_done,
  output logic [CNT_W-1:0] o_mean
);

  localparam int ACC_W = CNT_W + LOG2_AVG;

  logic [LEN_W-1:0] r_cnt;
  logic [ACC_W-1:0] r_acc;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
      r_acc <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
      r_acc <= '0;
    end else if (i_inc) begin
      r_cnt <= r_cnt + LEN_W'(1);
      r_acc <= r_acc + ACC_W'(i_sample);
    end
  end

  assign o_done = i_inc && (r_cnt == i_len - LEN_W'(1));
  assign o_mean = CNT_W'(r_acc >> LOG2_AVG);

endmodule

// File: rtl/coso_calib_ctrl.sv
// COSO TRNG calibration controller: sweeps CFG_B until the averaged
// beat count lands in [CMIN,CMAX], then gates random bits through.
module coso_calib_ctrl
  import coso_pkg::*;
#(
  parameter int N_SETTLE   = 4,
  parameter int LOG2_AVG   = 3,
  parameter int OFF_CYC    = 2,
  parameter int MISS_LIMIT = 4
) (
  input  logic             CLK,
  input  logic             RST_X,
  input  logic             EN,
  input  logic [CFG_W-1:0] BASE_A,
  input  logic [CNT_W-1:0] CMIN,
  input  logic [CNT_W-1:0] CMAX,
  input  logic [CNT_W-1:0] CNT_IN,
  input  logic             CNT_EN,
  output logic [CFG_W-1:0] CFG_A,
  output logic [CFG_W-1:0] CFG_B,
  output logic             RNG_EN,
  output logic             BUSY,
  output logic             LOCKED,
  output logic             FAIL,
  output logic             RND_BIT,
  output logic             RND_EN
);

  localparam int OFF_W  = $clog2(OFF_CYC + 1);
  localparam int MISS_W = $clog2(MISS_LIMIT + 1);

  state_t r_state;
  state_t w_nxt;

  logic [CFG_W-1:0]  r_cfg_a;
  logic [CFG_W-1:0]  r_cfg_b;
  logic [OFF_W-1:0]  r_off;
  logic [MISS_W-1:0] r_miss;

  logic r_rng_en;
  logic r_busy;
  logic r_locked;
  logic r_fail;
  logic r_rnd_bit;
  logic r_rnd_en;

  logic w_rng_en;
  logic w_busy;
  logic w_locked;
  logic w_fail;

  logic             w_clr;
  logic             w_inc;
  logic             w_done;
  logic [LEN_W-1:0] w_len;
  logic [CNT_W-1:0] w_mean;
  logic             w_mean_ok;
  logic             w_cnt_ok;
  logic             w_miss_trip;

  // One accumulator serves settle (count only) and measure (count + sum).
  assign w_inc = CNT_EN &&
                 (r_state == S_SETTLE || r_state == S_MEASURE);
  assign w_clr = !(r_state == S_SETTLE || r_state == S_MEASURE) ||
                 (r_state == S_SETTLE && w_done);
  assign w_len = (r_state == S_SETTLE) ?
                 LEN_W'(N_SETTLE) : LEN_W'(1 << LOG2_AVG);

  coso_sample_acc #(
    .LOG2_AVG (LOG2_AVG)
  ) u_acc (
    .i_clk    (CLK),
    .i_rst_n  (RST_X),
    .i_clr    (w_clr),
    .i_inc    (w_inc),
    .i_len    (w_len),
    .i_sample (CNT_IN),
    .o_done   (w_done),
    .o_mean   (w_mean)
  );

  assign w_mean_ok   = in_win(w_mean, CMIN, CMAX);
  assign w_cnt_ok    = in_win(CNT_IN, CMIN, CMAX);
  assign w_miss_trip = (r_state == S_LOCKED) && CNT_EN &&
                       !w_cnt_ok &&
                       (r_miss == MISS_W'(MISS_LIMIT - 1));

  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) r_state <= S_IDLE;
    else        r_state <= w_nxt;
  end

  always_comb begin
    w_nxt = r_state;
    if (!EN) begin
      w_nxt = S_IDLE;
    end else begin
      unique case (r_state)
        S_IDLE:
          w_nxt = (CMIN > CMAX) ? S_FAIL : S_RECONF;
        S_RECONF:
          if (r_off == OFF_W'(OFF_CYC - 1)) w_nxt = S_SETTLE;
        S_SETTLE:
          if (w_done) w_nxt = S_MEASURE;
        S_MEASURE:
          if (w_done) w_nxt = S_EVAL;
        S_EVAL:
          if (w_mean_ok)          w_nxt = S_LOCKED;
          else if (&r_cfg_b)      w_nxt = S_FAIL;
          else                    w_nxt = S_RECONF;
        S_LOCKED:
          if (w_miss_trip) w_nxt = S_RECONF;
        S_FAIL:
          w_nxt = S_FAIL;
        default:
          w_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    w_rng_en = 1'b0;
    w_busy   = 1'b0;
    w_locked = 1'b0;
    w_fail   = 1'b0;
    unique case (w_nxt)
      S_RECONF:  w_busy = 1'b1;
      S_SETTLE,
      S_MEASURE,
      S_EVAL: begin
        w_busy   = 1'b1;
        w_rng_en = 1'b1;
      end
      S_LOCKED: begin
        w_locked = 1'b1;
        w_rng_en = 1'b1;
      end
      S_FAIL:    w_fail = 1'b1;
      default:   ;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      r_rng_en  <= 1'b0;
      r_busy    <= 1'b0;
      r_locked  <= 1'b0;
      r_fail    <= 1'b0;
      r_rnd_bit <= 1'b0;
      r_rnd_en  <= 1'b0;
    end else begin
      r_rng_en  <= w_rng_en;
      r_busy    <= w_busy;
      r_locked  <= w_locked;
      r_fail    <= w_fail;
      r_rnd_bit <= CNT_IN[0];
      r_rnd_en  <= CNT_EN && (r_state == S_LOCKED) &&
                   (w_nxt == S_LOCKED);
    end
  end

  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      r_cfg_a <= '0;
      r_cfg_b <= '0;
    end else begin
      if (r_state == S_IDLE && w_nxt == S_RECONF) begin
        r_cfg_a <= BASE_A;
        r_cfg_b <= '0;
      end
      if (r_state == S_EVAL && w_nxt == S_RECONF)
        r_cfg_b <= r_cfg_b + CFG_W'(1);
      if (r_state == S_LOCKED && w_nxt == S_RECONF)
        r_cfg_b <= '0;
    end
  end

  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      r_off  <= '0;
      r_miss <= '0;
    end else begin
      if (r_state == S_RECONF && w_nxt == S_RECONF)
        r_off <= r_off + OFF_W'(1);
      else
        r_off <= '0;
      if (r_state != S_LOCKED || w_nxt != S_LOCKED)
        r_miss <= '0;
      else if (CNT_EN)
        r_miss <= w_cnt_ok ? '0 : r_miss + MISS_W'(1);
    end
  end

  assign CFG_A   = r_cfg_a;
  assign CFG_B   = r_cfg_b;
  assign RNG_EN  = r_rng_en;
  assign BUSY    = r_busy;
  assign LOCKED  = r_locked;
  assign FAIL    = r_fail;
  assign RND_BIT = r_rnd_bit;
  assign RND_EN  = r_rnd_en;

endmodule

// File: tb/tb_coso_calib_ctrl.sv
// Bench for coso_calib_ctrl: a beat-counter model drives random strobes,
// expected outcomes come from window arithmetic over per-candidate counts.
module tb_coso_calib_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [7:0] base_a, cmin, cmax, cnt_in;
  logic       cnt_en;
  logic [7:0] cfg_a, cfg_b;
  logic       rng_en, busy, locked, fail, rnd_bit, rnd_en;

  coso_calib_ctrl dut (
    .CLK(clk), .RST_X(rst_n), .EN(en),
    .BASE_A(base_a), .CMIN(cmin), .CMAX(cmax),
    .CNT_IN(cnt_in), .CNT_EN(cnt_en),
    .CFG_A(cfg_a), .CFG_B(cfg_b), .RNG_EN(rng_en),
    .BUSY(busy), .LOCKED(locked), .FAIL(fail),
    .RND_BIT(rnd_bit), .RND_EN(rnd_en)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // oscillator model
  logic [7:0] resp [256];
  logic [7:0] q [$];
  int  mode;
  bit  alt;
  bit  gen_on;
  int  gap, gmin, gmax;

  // monitors
  bit  mon_on;
  bit  last_strobe;
  logic prev_busy, prev_rng, prev_locked;
  int  pulses;
  int  pulse_cfg [$];

  task automatic tick();
    logic pe, pl, pb;
    if (gen_on && gap == 0) begin
      cnt_en = 1'b1;
      case (mode)
        0: cnt_in = resp[cfg_b];
        1: begin alt = ~alt; cnt_in = alt ? 8'd61 : 8'd60; end
        default: cnt_in = (q.size() > 0) ? q.pop_front() : 8'd50;
      endcase
      gap = $urandom_range(gmax, gmin);
    end else begin
      cnt_en = 1'b0;
      if (gap > 0) gap--;
    end
    pe = cnt_en; pl = locked; pb = cnt_in[0];
    prev_busy = busy; prev_rng = rng_en; prev_locked = locked;
    @(posedge clk); #1;
    last_strobe = pe;
    if (mon_on) begin
      checks++;
      if (rnd_en !== (pe & pl & locked)) begin
        errors++;
        $display("FAIL rnd_en got %b want %b", rnd_en, pe & pl & locked);
      end
      checks++;
      if (rnd_bit !== pb) begin
        errors++;
        $display("FAIL rnd_bit got %b want %b", rnd_bit, pb);
      end
      if (busy && !rng_en && !(prev_busy && !prev_rng)) begin
        pulses++;
        pulse_cfg.push_back(int'(cfg_b));
      end
    end
  endtask

  task automatic wait_done(input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      tick();
      if (locked || fail) begin ok = 1'b1; break; end
    end
  endtask

  task automatic restart(input logic [7:0] a, input logic [7:0] lo,
                         input logic [7:0] hi);
    en = 1'b0;
    tick(); tick();
    base_a = a; cmin = lo; cmax = hi;
    pulses = 0; pulse_cfg.delete();
    gap = 0; alt = 1'b0;
    en = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; base_a = 0; cmin = 0; cmax = 0;
    cnt_in = 0; cnt_en = 0; gen_on = 0; mon_on = 0;
    gmin = 0; gmax = 2; mode = 0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({cfg_a, cfg_b, rng_en, busy, locked, fail, rnd_bit, rnd_en} !== 22'd0) begin
      errors++;
      $display("FAIL reset_outputs got %h want 0",
               {cfg_a, cfg_b, rng_en, busy, locked, fail, rnd_bit, rnd_en});
    end
    rst_n = 1'b1;
    mon_on = 1'b1;
  endtask

  task automatic test_reset_mid();
    int n, i;
    bit ok;
    for (int b = 0; b < 256; b++) resp[b] = 8'd50;
    mode = 0; gen_on = 1; gmin = 0; gmax = 2;
    restart(8'h12, 8'd40, 8'd60);
    i = 0;
    while (!rng_en && i < 100) begin tick(); i++; end
    n = 0;
    while (n < 6 && i < 400) begin
      tick(); i++;
      if (last_strobe) n++;
    end
    checks++;
    if (n != 6 || !busy) begin
      errors++;
      $display("FAIL reach_measure got strobes %0d busy %b want 6 1", n, busy);
    end
    mon_on = 0;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({cfg_a, cfg_b, rng_en, busy, locked, fail, rnd_bit, rnd_en} !== 22'd0) begin
      errors++;
      $display("FAIL async_reset got %h want 0",
               {cfg_a, cfg_b, rng_en, busy, locked, fail, rnd_bit, rnd_en});
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    checks++;
    if ({cfg_a, cfg_b, rng_en, busy, locked, fail} !== 20'd0) begin
      errors++;
      $display("FAIL after_release got %h want 0",
               {cfg_a, cfg_b, rng_en, busy, locked, fail});
    end
    pulses = 0; pulse_cfg.delete();
    mon_on = 1;
    wait_done(2000, ok);
    checks++;
    if (!ok || !locked || cfg_b !== 8'd0 || cfg_a !== 8'h12) begin
      errors++;
      $display("FAIL restart_lock got ok %b lk %b b %0d a %h want 1 1 0 12",
               ok, locked, cfg_b, cfg_a);
    end
  endtask

  task automatic test_lock_first();
    int low, nstr, i;
    for (int b = 0; b < 256; b++) resp[b] = 8'd50;
    mode = 0; gen_on = 1; gmin = 2; gmax = 2;
    restart(8'h12, 8'd40, 8'd60);
    low = 0; nstr = 0; i = 0;
    while (!locked && i < 500) begin
      tick(); i++;
      if (busy && !rng_en) low++;
      if (last_strobe && prev_rng && !prev_locked) nstr++;
    end
    checks++;
    if (low != 2) begin
      errors++; $display("FAIL off_cycles got %0d want 2", low);
    end
    checks++;
    if (nstr != 12) begin
      errors++; $display("FAIL strobes_to_lock got %0d want 12", nstr);
    end
    checks++;
    if (!locked || cfg_a !== 8'h12 || cfg_b !== 8'd0 || busy || !rng_en) begin
      errors++;
      $display("FAIL first_lock got lk %b a %h b %0d busy %b rng %b",
               locked, cfg_a, cfg_b, busy, rng_en);
    end
    gmin = 0; gmax = 2;
    repeat (30) tick();
    en = 1'b0;
    tick();
    checks++;
    if (locked || rng_en || busy || cfg_a !== 8'h12 || cfg_b !== 8'd0) begin
      errors++;
      $display("FAIL en_low got lk %b rng %b busy %b a %h b %0d",
               locked, rng_en, busy, cfg_a, cfg_b);
    end
  endtask

  task automatic test_sweep();
    bit ok;
    for (int b = 0; b < 256; b++)
      resp[b] = (b <= 20) ? 8'(200 - 10 * b) : 8'd0;
    mode = 0; gen_on = 1; gmin = 0; gmax = 2;
    restart(8'h5a, 8'd40, 8'd60);
    wait_done(20000, ok);
    checks++;
    if (!ok || !locked || cfg_b !== 8'd14 || pulses != 15) begin
      errors++;
      $display("FAIL sweep got ok %b lk %b b %0d pulses %0d want 1 1 14 15",
               ok, locked, cfg_b, pulses);
    end
    for (int i = 0; i < pulse_cfg.size(); i++) begin
      checks++;
      if (pulse_cfg[i] != i) begin
        errors++;
        $display("FAIL sweep_step%0d got %0d want %0d", i, pulse_cfg[i], i);
      end
    end
  endtask

  task automatic test_random();
    bit ok;
    int lo, hi, exp_b;
    logic [7:0] a;
    for (int t = 0; t < 3; t++) begin
      lo = $urandom_range(200, 0);
      hi = lo + $urandom_range(55, 0);
      a  = 8'($urandom);
      for (int b = 0; b < 256; b++) resp[b] = 8'($urandom);
      exp_b = -1;
      for (int b = 0; b < 256; b++)
        if (exp_b < 0 && resp[b] >= lo && resp[b] <= hi) exp_b = b;
      mode = 0; gen_on = 1; gmin = 0; gmax = 1;
      restart(a, 8'(lo), 8'(hi));
      wait_done(20000, ok);
      checks++;
      if (exp_b >= 0) begin
        if (!ok || !locked || cfg_b !== 8'(exp_b) || cfg_a !== a ||
            pulses != exp_b + 1) begin
          errors++;
          $display("FAIL rand_lock%0d got lk %b b %0d a %h p %0d want b %0d a %h",
                   t, locked, cfg_b, cfg_a, pulses, exp_b, a);
        end
      end else begin
        if (!ok || !fail || cfg_b !== 8'd255) begin
          errors++;
          $display("FAIL rand_exh%0d got fl %b b %0d", t, fail, cfg_b);
        end
      end
    end
  endtask

  task automatic test_exhaust();
    bit ok;
    for (int b = 0; b < 256; b++) resp[b] = 8'd0;
    mode = 0; gen_on = 1; gmin = 0; gmax = 1;
    restart(8'h33, 8'd40, 8'd60);
    wait_done(20000, ok);
    checks++;
    if (!ok || !fail || locked || busy || rng_en || cfg_b !== 8'd255 ||
        pulses != 256) begin
      errors++;
      $display("FAIL exhaust got fl %b lk %b busy %b rng %b b %0d p %0d",
               fail, locked, busy, rng_en, cfg_b, pulses);
    end
    repeat (5) tick();
    checks++;
    if (!fail || cfg_b !== 8'd255) begin
      errors++;
      $display("FAIL fail_sticky got fl %b b %0d want 1 255", fail, cfg_b);
    end
    en = 1'b0;
    tick();
    checks++;
    if (fail || cfg_b !== 8'd255) begin
      errors++;
      $display("FAIL fail_clear got fl %b b %0d want 0 255", fail, cfg_b);
    end
  endtask

  task automatic test_drift();
    bit ok;
    int k, i;
    for (int b = 0; b < 256; b++) resp[b] = (b >= 3) ? 8'd50 : 8'd0;
    mode = 0; gen_on = 1; gmin = 0; gmax = 2;
    restart(8'h44, 8'd40, 8'd60);
    wait_done(5000, ok);
    checks++;
    if (!ok || !locked || cfg_b !== 8'd3) begin
      errors++;
      $display("FAIL drift_prelock got lk %b b %0d want 1 3", locked, cfg_b);
    end
    q = '{8'd100, 8'd10, 8'd100, 8'd50, 8'd100, 8'd100, 8'd5, 8'd200};
    mode = 2;
    k = 0; i = 0;
    while (k < 8 && i < 200) begin
      tick(); i++;
      if (last_strobe) begin
        k++;
        checks++;
        if (k < 8 && !locked) begin
          errors++;
          $display("FAIL drift_hold%0d got lk %b want 1", k, locked);
        end else if (k == 8 &&
                     (locked || cfg_b !== 8'd0 || !busy || rng_en)) begin
          errors++;
          $display("FAIL drift_trip got lk %b b %0d busy %b rng %b",
                   locked, cfg_b, busy, rng_en);
        end
      end
    end
    checks++;
    if (k != 8) begin
      errors++; $display("FAIL drift_timeout got %0d strobes want 8", k);
    end
    wait_done(5000, ok);
    checks++;
    if (!ok || !locked || cfg_b !== 8'd0) begin
      errors++;
      $display("FAIL drift_relock got lk %b b %0d want 1 0", locked, cfg_b);
    end
  endtask

  task automatic test_bad_window();
    int seen;
    gen_on = 1;
    en = 1'b0;
    tick(); tick();
    cmin = 8'd70; cmax = 8'd60;
    en = 1'b1;
    tick();
    checks++;
    if (!fail || busy || rng_en) begin
      errors++;
      $display("FAIL bad_window got fl %b busy %b rng %b want 1 0 0",
               fail, busy, rng_en);
    end
    seen = 0;
    repeat (6) begin tick(); if (rng_en) seen++; end
    checks++;
    if (seen != 0 || !fail) begin
      errors++;
      $display("FAIL bad_window_hold got rng %0d fl %b want 0 1", seen, fail);
    end
    en = 1'b0;
    tick();
  endtask

  task automatic test_trunc();
    bit ok;
    mode = 1; gen_on = 1; gmin = 0; gmax = 2;
    restart(8'h01, 8'd55, 8'd60);
    wait_done(2000, ok);
    checks++;
    if (!ok || !locked || cfg_b !== 8'd0) begin
      errors++;
      $display("FAIL trunc_lock got lk %b fl %b b %0d want 1 0 0",
               locked, fail, cfg_b);
    end
  endtask

  initial begin
    test_reset();
    test_lock_first();
    test_reset_mid();
    test_sweep();
    test_drift();
    test_bad_window();
    test_trunc();
    test_random();
    test_exhaust();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
